// File: rtl/win3x3_stream_ctrl_pkg.sv
// Shared definitions for the raster-stream blocks: FSM state codes and default geometry.
// Stream blocks import this package so that they agree on the FSM state encoding.
package win3x3_stream_ctrl_pkg;

  localparam int DEF_IMG_W = 512;
  localparam int DEF_IMG_H = 512;
  localparam int DEF_DW    = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

endpackage

// File: rtl/win3x3_stream_ctrl_line_buf.sv
// Delay line of DEPTH shift steps: dout is the value written DEPTH shifts ago.
// Read and write share the same pointer, so one read port and one write port suffice.
module win3x3_stream_ctrl_line_buf #(
  parameter int DEPTH = 512,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          shift,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};

  logic [DW-1:0] mem_r [DEPTH];
  logic [PW-1:0] ptr_r;

  assign dout = mem_r[ptr_r];

  // Storage write; contents need no reset
  always_ff @(posedge clk) begin
    if (shift) begin
      mem_r[ptr_r] <= din;
    end
  end

  // Circular pointer advance per shift step
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= PTR_ZERO;
    end else if (shift) begin
      ptr_r <= (ptr_r == PTR_LAST) ? PTR_ZERO : ptr_r + 1'b1;
    end
  end

endmodule

// File: rtl/win3x3_stream_ctrl.sv
// Turns a raster pixel stream into edge-replicated 3x3 windows, one per pixel, in raster order.
// Each shift step builds a vertical 3-pixel column; windows are assembled from the last columns.
module win3x3_stream_ctrl
  import win3x3_stream_ctrl_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int DW    = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_pixel,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] win1,
  output logic [DW-1:0] win2,
  output logic [DW-1:0] win3,
  output logic [DW-1:0] win4,
  output logic [DW-1:0] win5,
  output logic [DW-1:0] win6,
  output logic [DW-1:0] win7,
  output logic [DW-1:0] win8,
  output logic [DW-1:0] win9,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sof,
  output logic          out_eol,
  output logic          out_eof,
  output logic          busy
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_ZERO = {RW{1'b0}};
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [1:0]              state_r;
  logic [CW-1:0]           icol_r, ocol_r;
  logic [RW-1:0]           irow_r, orow_r;
  logic [2:0][DW-1:0]      p0_r, p1_r, col_s, lft_s, ctr_s, rgt_s;
  logic [8:0][DW-1:0]      win_r, taps_s;
  logic                    out_valid_r, sof_r, eol_r, eof_r;
  logic                    out_free_s, in_ready_s, accept_s, flush_step_s, step_s, produce_s;
  logic [DW-1:0]           d1_s, d2_s;

  win3x3_stream_ctrl_line_buf #(.DEPTH(IMG_W), .DW(DW)) u_lb1 (
    .clk(clk), .rst(rst), .shift(step_s), .din(in_pixel), .dout(d1_s)
  );
  win3x3_stream_ctrl_line_buf #(.DEPTH(IMG_W), .DW(DW)) u_lb2 (
    .clk(clk), .rst(rst), .shift(step_s), .din(d1_s), .dout(d2_s)
  );

  // Handshake qualification and shift/produce strobes
  always_comb begin
    out_free_s = !out_valid_r || out_ready;
    in_ready_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_FILL: in_ready_s = !rst;
      ST_RUN:           in_ready_s = !rst && out_free_s;
      ST_FLUSH:         in_ready_s = 1'b0;
      default:          in_ready_s = 1'b0;
    endcase
    accept_s     = in_valid && in_ready_s;
    flush_step_s = (state_r == ST_FLUSH) && out_free_s && !(out_valid_r && eof_r) && !rst;
    step_s       = accept_s || flush_step_s;
    produce_s    = flush_step_s || (accept_s && (state_r == ST_RUN));
  end

  // Column build with row clamping, then column selection with column clamping
  always_comb begin
    // Column is {row-2, row-1, row} of the pixel just stepped; flush replays the last row
    col_s[2] = ((state_r != ST_FLUSH) && (irow_r == ROW_ONE)) ? d1_s : d2_s;
    col_s[1] = d1_s;
    col_s[0] = (state_r == ST_FLUSH) ? d1_s : in_pixel;
    if (ocol_r == COL_ZERO) begin
      lft_s = p0_r;
      ctr_s = p0_r;
      rgt_s = col_s;
    end else if (ocol_r == COL_LAST) begin
      lft_s = p1_r;
      ctr_s = p0_r;
      rgt_s = p0_r;
    end else begin
      lft_s = p1_r;
      ctr_s = p0_r;
      rgt_s = col_s;
    end
    taps_s = {lft_s[2], ctr_s[2], rgt_s[2],
              lft_s[1], ctr_s[1], rgt_s[1],
              lft_s[0], ctr_s[0], rgt_s[0]};
  end

  // State, counters, column history and registered window outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      icol_r      <= COL_ZERO;
      irow_r      <= ROW_ZERO;
      ocol_r      <= COL_ZERO;
      orow_r      <= ROW_ZERO;
      p0_r        <= '0;
      p1_r        <= '0;
      win_r       <= '0;
      out_valid_r <= 1'b0;
      sof_r       <= 1'b0;
      eol_r       <= 1'b0;
      eof_r       <= 1'b0;
    end else begin
      if (step_s) begin
        p1_r <= p0_r;
        p0_r <= col_s;
      end
      if (accept_s) begin
        if (icol_r == COL_LAST) begin
          icol_r <= COL_ZERO;
          irow_r <= (irow_r == ROW_LAST) ? ROW_ZERO : irow_r + 1'b1;
        end else begin
          icol_r <= icol_r + 1'b1;
        end
      end
      if (produce_s) begin
        win_r       <= taps_s;
        out_valid_r <= 1'b1;
        sof_r       <= (ocol_r == COL_ZERO) && (orow_r == ROW_ZERO);
        eol_r       <= (ocol_r == COL_LAST);
        eof_r       <= (ocol_r == COL_LAST) && (orow_r == ROW_LAST);
        if (ocol_r == COL_LAST) begin
          ocol_r <= COL_ZERO;
          orow_r <= (orow_r == ROW_LAST) ? ROW_ZERO : orow_r + 1'b1;
        end else begin
          ocol_r <= ocol_r + 1'b1;
        end
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end
      case (state_r)
        ST_IDLE:  if (accept_s) state_r <= ST_FILL;
        ST_FILL:  if (accept_s && (irow_r == ROW_ONE) && (icol_r == COL_ZERO)) state_r <= ST_RUN;
        ST_RUN:   if (accept_s && (irow_r == ROW_LAST) && (icol_r == COL_LAST)) state_r <= ST_FLUSH;
        ST_FLUSH: if (out_valid_r && eof_r && out_ready) state_r <= ST_IDLE;
        default:  state_r <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_sof   = sof_r;
  assign out_eol   = eol_r;
  assign out_eof   = eof_r;
  assign busy      = (state_r != ST_IDLE);
  assign win1 = win_r[8];
  assign win2 = win_r[7];
  assign win3 = win_r[6];
  assign win4 = win_r[5];
  assign win5 = win_r[4];
  assign win6 = win_r[3];
  assign win7 = win_r[2];
  assign win8 = win_r[1];
  assign win9 = win_r[0];

endmodule

// File: tb/tb_win3x3_stream_ctrl.sv
// Self-checking bench for win3x3_stream_ctrl on a 4x3 image: clamp-based window model,
// randomized handshakes, back-to-back frames and mid-frame reset.
module tb_win3x3_stream_ctrl;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int DW = 8;
  localparam int N  = W * H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, in_ready, out_valid, out_ready;
  logic          out_sof, out_eol, out_eof, busy;
  logic [DW-1:0] in_pixel;
  logic [DW-1:0] win1, win2, win3, win4, win5, win6, win7, win8, win9;
  logic [71:0]   taps;
  logic [71:0]   win_log [N];
  logic [2:0]    flag_log [N];

  int n_cmp = 0;
  int n_bad = 0;

  assign taps = {win1, win2, win3, win4, win5, win6, win7, win8, win9};

  win3x3_stream_ctrl #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
    .win1(win1), .win2(win2), .win3(win3), .win4(win4), .win5(win5),
    .win6(win6), .win7(win7), .win8(win8), .win9(win9),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof), .busy(busy)
  );

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Window (r,c) of a frame whose pixel i equals base+i, from the clamp definition
  function automatic logic [71:0] model_win(input int base, input int idx);
    int r, c, rr, cc;
    logic [71:0] v;
    v = 72'd0;
    r = idx / W;
    c = idx % W;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        rr = (rr < 0) ? 0 : ((rr > H - 1) ? H - 1 : rr);
        cc = c + dc;
        cc = (cc < 0) ? 0 : ((cc > W - 1) ? W - 1 : cc);
        v = {v[63:0], DW'(base + rr * W + cc)};
      end
    end
    return v;
  endfunction

  task automatic run_frame(input int base, input int in_pct, input int out_pct, input bit strict);
    int pix = 0;
    int got = 0;
    int cyc = 0;
    int last_acc = -10;
    int flush_wins = 0;
    bit stall = 1'b0;
    logic [71:0] held = 72'd0;
    while (got < N && cyc < 400) begin
      @(negedge clk);
      in_valid  = (pix < N) && ($urandom_range(0, 99) < in_pct);
      in_pixel  = DW'(base + pix);
      out_ready = ($urandom_range(0, 99) < out_pct);
      #1;
      if (cyc == 0) begin
        chk("idle_busy", 72'(busy), 72'(0));
        chk("idle_in_ready", 72'(in_ready), 72'(1));
      end
      if (stall) begin
        chk("hold_valid", 72'(out_valid), 72'(1));
        chk("hold_taps", taps, held);
      end
      stall = out_valid && !out_ready;
      held  = taps;
      if (strict && pix <= W) begin
        chk("fill_in_ready", 72'(in_ready), 72'(1));
        chk("fill_no_window", 72'(out_valid), 72'(0));
      end
      if (pix == N) chk("flush_in_ready", 72'(in_ready), 72'(0));
      if (out_valid && out_ready) begin
        chk("taps", taps, model_win(base, got));
        chk("flags", 72'({out_sof, out_eol, out_eof}),
            72'({got == 0, (got % W) == W - 1, got == N - 1}));
        win_log[got]  = taps;
        flag_log[got] = {out_sof, out_eol, out_eof};
        if (cyc > last_acc + 1 && pix == N) flush_wins++;
        got++;
      end
      if (in_valid && in_ready) begin
        pix++;
        last_acc = cyc;
      end
      cyc++;
    end
    chk("window_count", 72'(got), 72'(N));
    chk("pixel_count", 72'(pix), 72'(N));
    if (strict) begin
      chk("flush_windows", 72'(flush_wins), 72'(W + 1));
      chk("frame_cycles", 72'(cyc), 72'(N + W + 2));
    end
  endtask

  task automatic reset_mid();
    int pix = 0;
    int cyc = 0;
    while (pix < 7 && cyc < 100) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_pixel  = DW'(pix);
      out_ready = 1'b1;
      #1;
      if (in_ready) pix++;
      cyc++;
    end
    chk("rst_pixels_before", 72'(pix), 72'(7));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_in_ready", 72'(in_ready), 72'(0));
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", 72'(out_valid), 72'(0));
    chk("rst_busy", 72'(busy), 72'(0));
  endtask

  task automatic check_scenario1();
    int s = 0;
    chk("w0_taps", win_log[0], {8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd4, 8'd4, 8'd5});
    chk("w0_sof", 72'(flag_log[0][2]), 72'(1));
    for (int i = 0; i < 9; i++) s += int'(win_log[0][i*8 +: 8]);
    chk("w0_kernel", 72'(s / 9), 72'(1));
    chk("w11_taps", win_log[5], {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10});
    chk("w23_taps", win_log[11], {8'd6, 8'd7, 8'd7, 8'd10, 8'd11, 8'd11, 8'd10, 8'd11, 8'd11});
    chk("w23_eol_eof", 72'(flag_log[11][1:0]), 72'(3));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pixel  = 8'd0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out_valid", 72'(out_valid), 72'(0));
    chk("reset_busy", 72'(busy), 72'(0));
    chk("reset_in_ready", 72'(in_ready), 72'(0));
    chk("reset_flags", 72'({out_sof, out_eol, out_eof}), 72'(0));
    chk("reset_taps", taps, 72'd0);
    @(negedge clk);
    rst = 1'b0;

    run_frame(0, 100, 100, 1'b1);
    check_scenario1();

    run_frame(0, 60, 50, 1'b0);
    run_frame(0, 40, 70, 1'b0);

    run_frame(0, 100, 100, 1'b1);
    run_frame(100, 100, 100, 1'b1);
    chk("f2_w0_taps", win_log[0], {8'd100, 8'd100, 8'd101, 8'd100, 8'd100, 8'd101, 8'd104, 8'd104, 8'd105});

    reset_mid();
    run_frame(0, 100, 100, 1'b1);
    check_scenario1();

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("tail_no_window", 72'(out_valid), 72'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/win3x3_stream_ctrl.md
Name: win3x3_stream_ctrl

Overview:
Sequences a raster pixel stream into 3x3 neighbourhood windows that feed the combinational 3x3 smoothing kernel's in1..in9 taps, one window per pixel, with edge replication at image borders. It owns the two line buffers, the raster position counters and the fill/run/flush state machine. It sits between the frame source and the kernel. The kernel result is consumed downstream, qualified by out_valid.

Parameters:
IMG_W, 512, pixels per row (>=3)
IMG_H, 512, rows per frame (>=3)
DW, 8, pixel width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
in_pixel  in  DW  raster-order input pixel
in_valid  in  1  in_pixel valid
in_ready  out  1  block accepts in_pixel this cycle
win1..win9  out  DW each  window taps, row-major: win1=(r-1,c-1), win5=(r,c), win9=(r+1,c+1)
out_valid  out  1  window valid
out_ready  in  1  downstream accepts window
out_sof  out  1  window is (0,0), qualified by out_valid
out_eol  out  1  window has c=IMG_W-1
out_eof  out  1  window is (IMG_H-1,IMG_W-1)
busy  out  1  state != IDLE

Behaviour:
- Clocking: single clock clk. Reset is synchronous, active-high (rst). All state updates on the rising edge of clk.
- Reset: state=IDLE; out_valid, out_sof/eol/eof=0; win1..win9=0; counters=0. in_ready=0 while rst=1. Line-buffer contents are don't-care.
- Handshakes: input transfer when in_valid&in_ready. Output transfer when out_valid&out_ready. Window outputs are registered and held stable while out_valid&!out_ready.
- Window definition: window (r,c) taps pixel (clamp(r+dr,0,IMG_H-1), clamp(c+dc,0,IMG_W-1)) for dr,dc in {-1,0,1}. This is edge replication: no zeros, no wrap between rows or frames.
- Emission rule: window (r,c) becomes emittable once pixel (min(r+1,IMG_H-1), min(c+1,IMG_W-1)) has been accepted. Windows are emitted strictly in raster order, exactly IMG_W*IMG_H per frame.
- FSM:
  - IDLE: in_ready=1. The first accepted pixel (index 0) moves to FILL.
  - FILL: in_ready=1. Accepts pixels up to index IMG_W, i.e. IMG_W+1 pixels total including the IDLE one. No windows are emitted. Moves to RUN after index IMG_W is accepted.
  - RUN: in_ready = !out_valid | out_ready. Each accepted pixel k (IMG_W+1..IMG_W*IMG_H-1) produces window k-IMG_W-1 at out_valid on the next cycle. Moves to FLUSH after the last pixel is accepted.
  - FLUSH: in_ready=0. Emits the remaining IMG_W+1 windows, one per output handshake. After the out_eof window transfers, returns to IDLE.
- Throughput: 1 window/cycle in RUN and FLUSH with out_ready held high. RUN latency is 1 cycle from input accept to out_valid.
- Counters: input column/row and output column/row counters, width $clog2 of IMG_W and IMG_H. Output counters wrap to 0 on frame end. out_sof/eol/eof are derived from the output counters.
- Stall in RUN: while out_valid=1 and out_ready=0, in_ready=0, so no input is lost and the window is unchanged.
- in_valid gaps: permitted in any state; there is no timeout.
- Back-to-back frames: the next frame's pixel 0 is accepted only in IDLE, which is reached in the cycle after the eof transfer. in_ready=1 in that cycle.
- rst mid-frame: frame discarded, return to reset state next cycle, no partial windows emitted.
- Arithmetic: taps are pass-through DW bits. No arithmetic on pixel data.

Decomposition:
- Shared package: FSM state encoding (IDLE, FILL, RUN, FLUSH) and default IMG_W/IMG_H/DW constants, reused by the other stream blocks.
- One natural sub-module, line_buf: single-port-read/single-write depth-IMG_W, DW-wide delay line, instantiated twice.
- The 3x3 tap register array, clamp muxing and FSM stay in the top.

Test Plan:
- IMG_W=4, IMG_H=3, pixels=index 0..11, out_ready=1: exactly 12 windows, in order. Window 0 taps = 0,0,1,0,0,1,4,4,5 with out_sof=1. Kernel result=1.
- Same frame, window (1,1) taps = 0,1,2,4,5,6,8,9,10. Window (2,3) taps = 6,7,7,10,11,11,10,11,11 with out_eof=1 and out_eol=1.
- Same frame: in_ready high for the first 5 pixels with out_valid=0. FLUSH emits 5 windows with in_ready=0. busy falls the cycle after the eof transfer.
- Random out_ready (50%) and in_valid gaps: taps are identical to the ungapped run. Windows are held stable during stalls. No duplicated or dropped windows (12 per frame).
- Two back-to-back frames with different data (second = 100+index): second frame's window 0 taps = 100,100,101,100,100,101,104,104,105. No first-frame data leaks.
- rst asserted one cycle after the 7th pixel: out_valid=0 and busy=0 next cycle. A subsequent full frame reproduces the first scenario exactly.
